// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds state encoding, data width and the baud-count helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic int baud_cnt_max(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser plus one delay flop for a serial line.
// Ports: sclk, rst_n, rx in; rx_sync (rx_s2), start_edge (1->0 seen) out.
module uart_sync (
  input  logic sclk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic start_edge
);

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  // Flops reset to the idle-high level so release never fakes an edge.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_sync    = rx_s2;
  assign start_edge = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: mid-bit sampling, one-cycle byte/error strobes.
// Ports: sclk, rst_n, rx in; po_data[7:0], po_flag, frame_err out.
// Build option: UART_RX_PARITY_EN adds an even-parity bit before stop.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] po_data,
  output logic              po_flag,
  output logic              frame_err
);

  localparam int BAUD_CNT_MAX =
    baud_cnt_max(CLK_FREQ, BAUD);
  localparam int CW = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID =
    CW'(BAUD_CNT_MAX / 2 - 1);

  logic              rx_sync;
  logic              start_edge;
  state_t            state;
  logic [CW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] sh;
  logic              strike;
  logic              wrap;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  uart_sync u_sync (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_sync    (rx_sync),
    .start_edge (start_edge)
  );

  assign strike = (baud_cnt == CNT_MID);
  assign wrap   = (baud_cnt == CNT_LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE)
        baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          // High at mid-start means the edge was a glitch.
          if (strike && rx_sync) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (strike) begin
            sh      <= {rx_sync, sh[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (wrap && bit_cnt == 4'd8) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
            bit_cnt <= '0;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (strike)
            par_bad <= ^{sh, rx_sync};
          if (wrap) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is caught.
          if (strike) begin
`ifdef UART_RX_PARITY_EN
            if (rx_sync && !par_bad) begin
`else
            if (rx_sync) begin
`endif
              po_data <= sh;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-parallel receiver: 8N1 asynchronous serial line in, one byte plus a one-cycle valid strobe out.
- Sits directly upstream of the 8-bit capture register. po_data drives its d input; po_flag is the load qualifier.
- Oversamples with a baud counter and samples each bit at its midpoint.

Parameters:
- CLK_FREQ, 50_000_000, sclk frequency in Hz.
- BAUD, 9600, line bit rate in bit/s.
- BAUD_CNT_MAX, CLK_FREQ/BAUD, sclk cycles per bit (derived localparam, integer divide, must be ≥ 4).

Ports:
- sclk  in  1  system clock, rising-edge.
- rst_n  in  1  reset.
- rx  in  1  asynchronous serial line, idle high.
- po_data  out  8  last correctly received byte.
- po_flag  out  1  one-cycle pulse, po_data newly valid.
- frame_err  out  1  one-cycle pulse, bad stop bit (or parity, see below).

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is sclk. All flops clear immediately when rst_n is low.
- Reset values: po_data=8'h00, po_flag=0, frame_err=0, state=IDLE, counters=0, synchroniser flops=1.
- Input synchronisation: rx passes through a 2-flop synchroniser (rx_s1, rx_s2) plus a third delay flop rx_s3. Start detect is rx_s3=1 && rx_s2=0.
- baud_cnt: counts 0..BAUD_CNT_MAX-1 and wraps. Held at 0 in IDLE.
- Sample strike: occurs when baud_cnt == BAUD_CNT_MAX/2 - 1. Value sampled is rx_s2.
- bit_cnt: 0..8 within DATA, cleared on each state entry.
- State IDLE: on start detect, go to START and clear baud_cnt. Otherwise stay.
- State START: at the sample strike:
  - rx_s2=1 is a false start (glitch) → IDLE. No pulse on any output.
  - rx_s2=0 → DATA at the next baud_cnt wrap.
- State DATA: one bit sampled per bit period, LSB first, into shift register sh[7:0] (shift right, new bit into sh[7]). After 8 samples → STOP at the wrap.
- State STOP: at the sample strike:
  - rx_s2=1: po_data<=sh, po_flag=1 for exactly one cycle.
  - rx_s2=0: frame_err=1 for one cycle, po_data unchanged.
  - Either way, go to IDLE on the same edge. Returning at mid-stop leaves half a bit of margin for back-to-back frames.
- Latency: po_flag rises 9*BAUD_CNT_MAX + BAUD_CNT_MAX/2 + 3 sclk cycles after the rx pin falling edge. Bench tolerance is ±1 cycle.
- Output holding: po_data holds its value between frames. po_flag and frame_err are never high together.
- Start detect outside IDLE: ignored.
- rx stuck low: after a frame error, IDLE sees no 1→0 edge, so nothing further happens until the line returns high.
- Reset mid-frame: state returns to IDLE immediately with no pulse. po_data returns to 8'h00.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP. One bit is sampled at the strike; even parity over sh plus the parity bit is required.
  - On mismatch the frame still runs through STOP. At the STOP strike, frame_err pulses instead of po_flag, and po_data is not updated.
  - Latency grows by BAUD_CNT_MAX.
- Undefined: no PARITY state, 8N1 only. Encoding and ports are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit;
  - DATA_W=8;
  - the baud-count helper function.
- One natural sub-module: uart_sync, the 2-flop synchroniser plus edge-detect flop, with outputs rx_sync and start_edge. Reusable by a future transmitter's CTS input.
- Everything else lives in uart_byte_rx.

Test Plan (bench overrides CLK_FREQ=1_000_000, BAUD=100_000 → BAUD_CNT_MAX=10):
- Frame 0x55 (line bits 0,1,0,1,0,1,0,1,0,1) → po_flag single pulse at ~98 cycles after start edge, po_data=8'h55, frame_err stays 0.
- Frame 0xA3 then immediately frame 0x3C, no idle gap → two po_flag pulses 100 cycles apart, po_data 8'hA3 then 8'h3C.
- rx low for 3 cycles then high (glitch) → no po_flag, no frame_err, state back in IDLE. A following frame 0x81 is received correctly.
- Frame 0x7E with stop bit 0 → frame_err one-cycle pulse, po_flag 0, po_data keeps prior value.
- rst_n low for 2 cycles during bit 4 of frame 0xFF → outputs 00/0/0. The next full frame 0x12 → po_data=8'h12.
- With UART_RX_PARITY_EN:
  - 0x07 with parity 1 → po_flag pulse, po_data=8'h07.
  - 0x07 with parity 0 → frame_err pulse, po_data unchanged.
